// File: rtl/serial_complement2_ctrl.sv
// serial_complement2_ctrl: bit-serial two's complement negation (~a + 1).
// An accepted operand is inverted into a shift register and pushed LSB first
// through a single full-adder slice seeded with carry=1, one bit per clock,
// over WIDTH cycles. The result is then held with a valid/ready handshake.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand offered on in_data
//   in_ready   block is idle and can accept an operand
//   in_data    operand to negate
//   out_valid  result presented on out_data/carry_out
//   out_ready  consumer accepts result
//   out_data   two's complement of the accepted operand
//   carry_out  carry out of the MSB position of ~a + 1 (set only for a == 0)
//   busy       high whenever the block is not idle
//   ovf        (OVERFLOW_FLAG_EN only) operand was the most negative value
//
// Optional feature macro: OVERFLOW_FLAG_EN adds the ovf port and its register.

module serial_complement2_ctrl #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             carry_out,
    output logic             busy
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               in_ready_d;
    logic               out_valid_d;
    logic               busy_d;
    logic               accept_c;
    logic               last_bit_c;
    logic [WIDTH-1:0]   op_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;

    assign accept_c   = (state_q == IDLE) && in_valid;
    assign last_bit_c = (state_q == CALC) && (cnt_q == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = CALC;
            CALC:    if (last_bit_c) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake/status outputs decoded from the next state so the flops
    // line up with the state register on the same edge.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b1;
        case (state_d)
            IDLE: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
            DONE:    out_valid_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Serial datapath: one full-adder slice, result fills from the MSB end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else if (accept_c) begin
            op_q    <= ~in_data;
            carry_q <= 1'b1;
            cnt_q   <= '0;
        end else if (state_q == CALC) begin
            op_q     <= {1'b0, op_q[WIDTH-1:1]};
            carry_q  <= op_q[0] & carry_q;
            result_q <= {op_q[0] ^ carry_q, result_q[WIDTH-1:1]};
            cnt_q    <= CNT_W'(cnt_q + 1'b1);
        end
    end

    assign out_data  = result_q;
    assign carry_out = carry_q;

`ifdef OVERFLOW_FLAG_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Inverted most-negative value is 0111..1; flag is held until next accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (accept_c) begin
            ovf <= (~in_data == ~MOST_NEG);
        end
    end
`endif

endmodule

// File: tb/tb_serial_complement2_ctrl.sv
// Scoreboard bench for serial_complement2_ctrl: accepted operands push their
// arithmetic negation into a queue; a monitor compares handshake status,
// latency and results every cycle against that queue.

module tb_serial_complement2_ctrl;

    localparam int unsigned W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         carry_out;
    logic         busy;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    serial_complement2_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .carry_out (carry_out),
        .busy      (busy)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         carry;
        logic         ovf;
        int unsigned  acc;
    } exp_t;

    exp_t        q[$];
    int unsigned pos_cnt = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          rst_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, pos_cnt);
        end
    endtask

    always @(posedge clk) pos_cnt++;

    // Reference: negation modulo 2^W computed arithmetically
    function automatic exp_t model(input logic [W-1:0] a, input int unsigned acc);
        exp_t e;
        int unsigned m;
        m = 1 << W;
        e.data  = W'((m - int'(a)) % m);
        e.carry = (a == '0);
        e.ovf   = (int'(a) == (m >> 1));
        e.acc   = acc;
        return e;
    endfunction

    // Push side: record accept and reset events for the edge that follows
    initial begin
        bit           acc;
        bit           rs;
        logic [W-1:0] d;
        forever begin
            @(negedge clk);
            acc = in_valid && in_ready && rst_n;
            rs  = !rst_n;
            d   = in_data;
            @(posedge clk);
            #1;
            rst_done = rs;
            if (rs) q.delete();
            if (acc) q.push_back(model(d, pos_cnt));
        end
    end

    // Monitor: status, latency and result held stable while valid
    initial begin
        bit exp_busy;
        bit exp_ov;
        forever begin
            @(negedge clk);
            #1;
            exp_busy = (q.size() != 0);
            exp_ov   = exp_busy && (pos_cnt >= q[0].acc + W);
            check("in_ready", 32'(in_ready), 32'(!exp_busy));
            check("busy", 32'(busy), 32'(exp_busy));
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            if (rst_done) begin
                check("rst_out_data", 32'(out_data), 32'd0);
                check("rst_carry", 32'(carry_out), 32'd0);
`ifdef OVERFLOW_FLAG_EN
                check("rst_ovf", 32'(ovf), 32'd0);
`endif
            end
            if (exp_ov) begin
                check("out_data", 32'(out_data), 32'(q[0].data));
                check("carry_out", 32'(carry_out), 32'(q[0].carry));
`ifdef OVERFLOW_FLAG_EN
                check("ovf", 32'(ovf), 32'(q[0].ovf));
`endif
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [W-1:0] op);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = op;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready && rst_n) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", 32'(ok), 32'd1);
        step();
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("valid_timeout", 32'(ok), 32'd1);
        step();
    endtask

    task automatic wait_out();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("handshake_timeout", 32'(ok), 32'd1);
        step();
    endtask

    initial begin
        logic [W-1:0] ops [5];
        ops[0] = 6'b000011;
        ops[1] = 6'b111100;
        ops[2] = 6'b111111;
        ops[3] = 6'b000000;
        ops[4] = 6'b100000;

        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Directed operands with the consumer always ready
        out_ready = 1'b1;
        foreach (ops[i]) begin
            send(ops[i]);
            wait_out();
        end

        // Backpressure: hold result while a different operand is offered
        out_ready = 1'b0;
        send(6'b000011);
        wait_valid();
        in_valid = 1'b1;
        in_data  = 6'b101010;
        repeat (5) step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_out();

        // Reset on the third cycle after accept, then a normal operation
        send(6'b000011);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        send(6'b111100);
        wait_out();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 79) != 0);
            step();
        end

        // Drain anything outstanding
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (W + 6) step();
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
